// File: rtl/oscillator_bank.sv
// Multi-voice phase-accumulator oscillator bank with wave-table index generation and a mixer.
// Optional macro OSC_MIX_SATURATE_EN: clamp the full mix sum instead of scaling it down.
module oscillator_bank #(
    parameter int unsigned NUM_OSCILLATORS = 4,
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned WW_WIDTH        = 18,
    parameter int unsigned PHASE_FRAC      = 8
) (
    input  logic                                               clk_in,
    input  logic                                               rst_in,
    input  logic                                               sample_tick_in,
    input  logic                                               ui_update_trig_in,
    input  logic [WW_WIDTH-1:0]                                wave_width_in,
    input  logic [NUM_OSCILLATORS-1:0]                         osc_is_on_in,
    input  logic [NUM_OSCILLATORS*(WW_WIDTH+PHASE_FRAC)-1:0]   phase_inc_in,
    output logic [NUM_OSCILLATORS*WW_WIDTH-1:0]                osc_index_out,
    input  logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0]            osc_data_in,
    output logic [SAMPLE_WIDTH-1:0]                            audio_out,
    output logic                                               audio_valid_out,
    output logic                                               overrun_out
);

    localparam int unsigned PW   = WW_WIDTH + PHASE_FRAC;
    localparam int unsigned LOGN = $clog2(NUM_OSCILLATORS);
    localparam int unsigned SUMW = SAMPLE_WIDTH + LOGN;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADVANCE = 3'd1,
        WAIT1   = 3'd2,
        WAIT2   = 3'd3,
        MIX     = 3'd4
    } state_t;

    state_t                                state;
    logic [NUM_OSCILLATORS-1:0][PW-1:0]    phase;
    logic [NUM_OSCILLATORS-1:0][PW:0]      acc_c;
    logic [NUM_OSCILLATORS-1:0][PW:0]      red_c;
    logic [NUM_OSCILLATORS-1:0][PW-1:0]    phase_nxt_c;
    logic [PW:0]                           wrap_c;
    logic signed [SUMW-1:0]                sum_c;
    logic [SAMPLE_WIDTH-1:0]               audio_c;

    assign wrap_c = {1'b0, wave_width_in, {PHASE_FRAC{1'b0}}};

    // Next phase: one conditional wrap; a step that still overshoots restarts at 0
    always_comb begin
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            acc_c[i] = {1'b0, phase[i]} + {1'b0, phase_inc_in[i*PW +: PW]};
            red_c[i] = acc_c[i] - wrap_c;
            if (wave_width_in == '0)
                phase_nxt_c[i] = '0;
            else if (acc_c[i][PW:PHASE_FRAC] < {1'b0, wave_width_in})
                phase_nxt_c[i] = acc_c[i][PW-1:0];
            else if (red_c[i][PW:PHASE_FRAC] < {1'b0, wave_width_in})
                phase_nxt_c[i] = red_c[i][PW-1:0];
            else
                phase_nxt_c[i] = '0;
        end
    end

    // Full-precision sum of sign-extended samples from enabled voices
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            if (osc_is_on_in[i])
                sum_c = sum_c + SUMW'($signed(osc_data_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
        end
    end

`ifdef OSC_MIX_SATURATE_EN
    localparam logic signed [SUMW-1:0] SAT_MAX = {{(LOGN+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SUMW-1:0] SAT_MIN = {{(LOGN+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    always_comb begin
        if (sum_c > SAT_MAX)
            audio_c = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        else if (sum_c < SAT_MIN)
            audio_c = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        else
            audio_c = sum_c[SAMPLE_WIDTH-1:0];
    end
`else
    // Arithmetic shift by LOGN is exactly the top SAMPLE_WIDTH bits of the sum
    assign audio_c = sum_c[SUMW-1:LOGN];
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            phase           <= '0;
            osc_index_out   <= '0;
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            audio_valid_out <= 1'b0;
            if (ui_update_trig_in) begin
                state         <= IDLE;
                phase         <= '0;
                osc_index_out <= '0;
            end else begin
                if (sample_tick_in && state != IDLE)
                    overrun_out <= 1'b1;
                case (state)
                    IDLE: begin
                        if (sample_tick_in)
                            state <= ADVANCE;
                    end
                    ADVANCE: begin
                        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                            phase[i]                                 <= phase_nxt_c[i];
                            osc_index_out[i*WW_WIDTH +: WW_WIDTH]   <= phase_nxt_c[i][PW-1:PHASE_FRAC];
                        end
                        state <= WAIT1;
                    end
                    WAIT1:   state <= WAIT2;
                    WAIT2:   state <= MIX;
                    MIX: begin
                        audio_out       <= audio_c;
                        audio_valid_out <= 1'b1;
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
                // Disabled voices sit at index 0 so re-enabling restarts them cleanly
                for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                    if (!osc_is_on_in[i]) begin
                        phase[i]                               <= '0;
                        osc_index_out[i*WW_WIDTH +: WW_WIDTH] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_oscillator_bank.sv
// Directed bench for oscillator_bank: phase stepping, mixing, overrun, reload and reset behaviour.
module tb_oscillator_bank;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 16;
    localparam int unsigned WW = 18;
    localparam int unsigned PF = 8;
    localparam int unsigned PW = WW + PF;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  sample_tick_in;
    logic                  ui_update_trig_in;
    logic [WW-1:0]         wave_width_in;
    logic [N-1:0]          osc_is_on_in;
    logic [N*PW-1:0]       phase_inc_in;
    logic [N*WW-1:0]       osc_index_out;
    logic [N*SW-1:0]       osc_data_in;
    logic [SW-1:0]         audio_out;
    logic                  audio_valid_out;
    logic                  overrun_out;

    int checks   = 0;
    int failures = 0;

    oscillator_bank #(
        .NUM_OSCILLATORS(N),
        .SAMPLE_WIDTH(SW),
        .WW_WIDTH(WW),
        .PHASE_FRAC(PF)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .sample_tick_in(sample_tick_in),
        .ui_update_trig_in(ui_update_trig_in),
        .wave_width_in(wave_width_in),
        .osc_is_on_in(osc_is_on_in),
        .phase_inc_in(phase_inc_in),
        .osc_index_out(osc_index_out),
        .osc_data_in(osc_data_in),
        .audio_out(audio_out),
        .audio_valid_out(audio_valid_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_edge();
        @(posedge clk_in);
        #1;
    endtask

    // Issue one tick and watch nine edges; edge 1 is the one that samples the tick
    task automatic do_tick(output int npulse, output int pos, output logic [WW-1:0] idx0);
        sample_tick_in = 1'b1;
        tick_edge();
        sample_tick_in = 1'b0;
        npulse = 0;
        pos    = 0;
        idx0   = '0;
        for (int k = 2; k <= 9; k++) begin
            tick_edge();
            if (k == 2)
                idx0 = osc_index_out[WW-1:0];
            if (audio_valid_out) begin
                npulse++;
                if (pos == 0)
                    pos = k;
            end
        end
    endtask

    int            np;
    int            ps;
    logic [WW-1:0] ix;
    logic [WW-1:0] exp_idx [4];
    logic [SW-1:0] exp_audio;

    initial begin
        rst_in            = 1'b0;
        sample_tick_in    = 1'b0;
        ui_update_trig_in = 1'b0;
        wave_width_in     = WW'(4);
        osc_is_on_in      = '0;
        phase_inc_in      = '0;
        osc_data_in       = '0;

        // Tick held during reset must not start a frame
        sample_tick_in = 1'b1;
        tick_edge();
        tick_edge();
        check("rst_audio", 32'(audio_out), 32'h0);
        check("rst_valid", 32'(audio_valid_out), 32'h0);
        check("rst_overrun", 32'(overrun_out), 32'h0);
        check("rst_index", 32'(osc_index_out == '0), 32'h1);
        rst_in         = 1'b1;
        sample_tick_in = 1'b0;
        np = 0;
        for (int k = 0; k < 6; k++) begin
            tick_edge();
            if (audio_valid_out) np++;
        end
        check("rst_release_no_pulse", 32'(np), 32'h0);

        // Voice 0 at 1.5 samples/tick over a 4-sample table
        osc_is_on_in = 4'b0001;
        for (int i = 0; i < N; i++) phase_inc_in[i*PW +: PW] = PW'(32'h180);
        exp_idx[0] = WW'(1); exp_idx[1] = WW'(3); exp_idx[2] = WW'(0); exp_idx[3] = WW'(2);
        for (int t = 0; t < 4; t++) begin
            do_tick(np, ps, ix);
            check($sformatf("step_idx%0d", t), 32'(ix), 32'(exp_idx[t]));
            check($sformatf("step_pos%0d", t), 32'(ps), 32'd5);
            check($sformatf("step_cnt%0d", t), 32'(np), 32'd1);
        end
        check("disabled_idx1", 32'(osc_index_out[WW +: WW]), 32'h0);

        // All four voices at +0x4000
        osc_is_on_in = 4'b1111;
        osc_data_in  = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
`ifdef OSC_MIX_SATURATE_EN
        exp_audio = 16'h7FFF;
`else
        exp_audio = 16'h4000;
`endif
        do_tick(np, ps, ix);
        check("mix_all_pos", 32'(audio_out), 32'(exp_audio));

        // Negative full-scale on voice 0, disabled voices carry data that must be ignored
        osc_is_on_in = 4'b0011;
        osc_data_in  = {16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000};
`ifdef OSC_MIX_SATURATE_EN
        exp_audio = 16'h8000;
`else
        exp_audio = 16'hE000;
`endif
        do_tick(np, ps, ix);
        check("mix_neg", 32'(audio_out), 32'(exp_audio));
        for (int k = 0; k < 5; k++) tick_edge();
        check("audio_hold", 32'(audio_out), 32'(exp_audio));

        // Reload zeroes every index
        ui_update_trig_in = 1'b1;
        tick_edge();
        ui_update_trig_in = 1'b0;
        check("reload_index", 32'(osc_index_out == '0), 32'h1);

        // Second tick while busy is dropped and flags overrun
        osc_is_on_in   = 4'b0001;
        sample_tick_in = 1'b1;
        tick_edge();
        sample_tick_in = 1'b0;
        tick_edge();
        sample_tick_in = 1'b1;
        tick_edge();
        sample_tick_in = 1'b0;
        np = 0;
        for (int k = 0; k < 9; k++) begin
            tick_edge();
            if (audio_valid_out) np++;
        end
        check("overrun_pulses", 32'(np), 32'd1);
        check("overrun_flag", 32'(overrun_out), 32'h1);
        check("overrun_idx", 32'(osc_index_out[WW-1:0]), 32'd1);
        do_tick(np, ps, ix);
        check("overrun_sticky", 32'(overrun_out), 32'h1);
        check("overrun_next_idx", 32'(ix), 32'd3);

        // Asynchronous reset mid-frame clears outputs before the next edge
        sample_tick_in = 1'b1;
        tick_edge();
        sample_tick_in = 1'b0;
        tick_edge();
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_audio", 32'(audio_out), 32'h0);
        check("arst_overrun", 32'(overrun_out), 32'h0);
        check("arst_index", 32'(osc_index_out == '0), 32'h1);
        check("arst_valid", 32'(audio_valid_out), 32'h0);
        tick_edge();
        tick_edge();
        rst_in = 1'b1;
        np = 0;
        for (int k = 0; k < 8; k++) begin
            tick_edge();
            if (audio_valid_out) np++;
        end
        check("arst_no_pulse", 32'(np), 32'h0);

        // Reload during WAIT2 cancels the frame
        sample_tick_in = 1'b1;
        tick_edge();
        sample_tick_in = 1'b0;
        tick_edge();
        tick_edge();
        ui_update_trig_in = 1'b1;
        np = 0;
        for (int k = 0; k < 8; k++) begin
            tick_edge();
            ui_update_trig_in = 1'b0;
            if (audio_valid_out) np++;
        end
        check("reload_no_pulse", 32'(np), 32'h0);
        check("reload_mid_index", 32'(osc_index_out == '0), 32'h1);
        do_tick(np, ps, ix);
        check("reload_restart_idx", 32'(ix), 32'd1);
        check("reload_restart_pos", 32'(ps), 32'd5);

        // Reload coincident with a busy-state tick wins without flagging overrun
        sample_tick_in = 1'b1;
        tick_edge();
        ui_update_trig_in = 1'b1;
        np = 0;
        for (int k = 0; k < 8; k++) begin
            tick_edge();
            sample_tick_in    = 1'b0;
            ui_update_trig_in = 1'b0;
            if (audio_valid_out) np++;
        end
        check("coinc_overrun", 32'(overrun_out), 32'h0);
        check("coinc_no_pulse", 32'(np), 32'h0);
        check("coinc_index", 32'(osc_index_out == '0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
